// File: rtl/xy_router_node.sv
// xy_router_node: one mesh node, a registered 4-port (W/E/S/N) x CH_NUM crosspoint.
// Every output port/channel has its own FIFO; channel i only ever feeds channel i.
// Off-diagonal nodes (DIAG=0) pass traffic straight through to the opposite port.
// Diagonal nodes (DIAG=1) merge W/N/S onto E using a per-channel round-robin arbiter,
// and steer E traffic to W/S/N using the 2-bit direction field of the payload.
module xy_router_node #(
  parameter int CH_NUM     = 8,
  parameter int PLD_W      = 64,
  parameter int DIR_LSB    = 0,
  parameter int FIFO_DEPTH = 2,
  parameter int DIAG       = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0][CH_NUM-1:0]               in_vld,
  input  logic [3:0][CH_NUM-1:0][PLD_W-1:0]    in_pld,
  output logic [3:0][CH_NUM-1:0]               in_rdy,
  output logic [3:0][CH_NUM-1:0]               out_vld,
  output logic [3:0][CH_NUM-1:0][PLD_W-1:0]    out_pld,
  input  logic [3:0][CH_NUM-1:0]               out_rdy,
  output logic                                 route_err,
  output logic [15:0]                          stall_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] P_W = 2'd0;
  localparam logic [1:0] P_E = 2'd1;
  localparam logic [1:0] P_S = 2'd2;
  localparam logic [1:0] P_N = 2'd3;

  // Round-robin pointer for the E merge: the source holding highest priority.
  typedef enum logic [1:0] {RR_W = 2'd0, RR_N = 2'd1, RR_S = 2'd2} rr_e;

  logic [PLD_W-1:0] mem      [4][CH_NUM][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr   [4][CH_NUM];
  logic [AW-1:0]    rd_ptr   [4][CH_NUM];
  logic [AW:0]      cnt      [4][CH_NUM];
  logic [PLD_W-1:0] last_pld [4][CH_NUM];
  rr_e              rr_ptr   [CH_NUM];
  rr_e              rr_nxt   [CH_NUM];

  logic [3:0][CH_NUM-1:0]            full;
  logic [3:0][CH_NUM-1:0]            empty;
  logic [3:0][CH_NUM-1:0]            pop;
  logic [3:0][CH_NUM-1:0]            push;
  logic [3:0][CH_NUM-1:0][PLD_W-1:0] push_pld;
  logic [CH_NUM-1:0]                 err_hit;
  logic                              stall_any;

  logic [3:0] req;
  logic       gnt_ok;
  logic [1:0] gnt_idx;
  logic [1:0] idx;
  logic [1:0] src;
  logic [1:0] dir;
  logic [1:0] tgt;

  // FIFO status and output presentation; an empty FIFO shows the last value it popped
  // so that idle payloads hold steady instead of exposing stale storage.
  always_comb begin
    full    = '0;
    empty   = '0;
    pop     = '0;
    out_vld = '0;
    out_pld = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        full[d][c]    = (cnt[d][c] == DEPTH_C);
        empty[d][c]   = (cnt[d][c] == '0);
        out_vld[d][c] = !empty[d][c];
        pop[d][c]     = !empty[d][c] && out_rdy[d][c];
        out_pld[d][c] = empty[d][c] ? last_pld[d][c] : mem[d][c][rd_ptr[d][c]];
      end
    end
  end

  // Routing: in_rdy, FIFO pushes, round-robin grant and misroute detection.
  always_comb begin
    in_rdy   = '0;
    push     = '0;
    push_pld = '0;
    err_hit  = '0;
    rr_nxt   = rr_ptr;
    req      = '0;
    gnt_ok   = 1'b0;
    gnt_idx  = '0;
    idx      = '0;
    src      = P_W;
    dir      = '0;
    tgt      = P_W;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (DIAG == 0) begin
        for (int unsigned d = 0; d < 4; d++) begin
          in_rdy[d][c]        = !full[d ^ 1][c];
          push[d ^ 1][c]      = in_vld[d][c] && !full[d ^ 1][c];
          push_pld[d ^ 1][c]  = in_pld[d][c];
        end
      end else begin
        // Merge: candidate index 0=W, 1=N, 2=S, searched starting at the pointer.
        req     = {1'b0, in_vld[P_S][c], in_vld[P_N][c], in_vld[P_W][c]};
        gnt_ok  = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < 3; k++) begin
          idx = 2'((32'(rr_ptr[c]) + k) % 3);
          if (!gnt_ok && req[idx]) begin
            gnt_ok  = 1'b1;
            gnt_idx = idx;
          end
        end
        if (gnt_ok && !full[P_E][c]) begin
          src = (gnt_idx == 2'd0) ? P_W : (gnt_idx == 2'd1) ? P_N : P_S;
          in_rdy[src][c]  = 1'b1;
          push[P_E][c]    = 1'b1;
          push_pld[P_E][c] = in_pld[src][c];
          rr_nxt[c]       = rr_e'(2'((32'(gnt_idx) + 1) % 3));
        end
        // Steer: direction EAST has no legal target, so it is swallowed and flagged.
        dir = in_pld[P_E][c][DIR_LSB +: 2];
        case (dir)
          2'b00:   tgt = P_W;
          2'b10:   tgt = P_S;
          2'b11:   tgt = P_N;
          default: tgt = P_E;
        endcase
        if (tgt == P_E) begin
          in_rdy[P_E][c] = 1'b1;
          err_hit[c]     = in_vld[P_E][c];
        end else begin
          in_rdy[P_E][c]  = !full[tgt][c];
          push[tgt][c]    = in_vld[P_E][c] && !full[tgt][c];
          push_pld[tgt][c] = in_pld[P_E][c];
        end
      end
    end
  end

  // Any offered beat that is not accepted this cycle counts as a stall.
  always_comb begin
    stall_any = |(in_vld & ~in_rdy);
  end

  // FIFO payload storage; contents need no reset because only valid entries are shown.
  always_ff @(posedge clk) begin
    for (int unsigned d = 0; d < 4; d++) begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        if (push[d][c]) mem[d][c][wr_ptr[d][c]] <= push_pld[d][c];
      end
    end
  end

  // FIFO pointers/occupancy, held payload, and arbiter pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned d = 0; d < 4; d++) begin
        for (int unsigned c = 0; c < CH_NUM; c++) begin
          wr_ptr[d][c]   <= '0;
          rd_ptr[d][c]   <= '0;
          cnt[d][c]      <= '0;
          last_pld[d][c] <= '0;
        end
      end
      for (int unsigned c = 0; c < CH_NUM; c++) rr_ptr[c] <= RR_W;
    end else begin
      for (int unsigned d = 0; d < 4; d++) begin
        for (int unsigned c = 0; c < CH_NUM; c++) begin
          if (push[d][c]) wr_ptr[d][c] <= wr_ptr[d][c] + 1'b1;
          if (pop[d][c]) begin
            rd_ptr[d][c]   <= rd_ptr[d][c] + 1'b1;
            last_pld[d][c] <= mem[d][c][rd_ptr[d][c]];
          end
          if (push[d][c] && !pop[d][c])      cnt[d][c] <= cnt[d][c] + 1'b1;
          else if (!push[d][c] && pop[d][c]) cnt[d][c] <= cnt[d][c] - 1'b1;
        end
      end
      rr_ptr <= rr_nxt;
    end
  end

  // Sticky misroute flag and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (|err_hit) route_err <= 1'b1;
      if (stall_any && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_xy_router_node.sv
// Directed bench for xy_router_node: one straight-through node and one diagonal node.
module tb_xy_router_node;

  localparam int CH = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0][CH-1:0]         s_in_vld, s_in_rdy, s_out_vld, s_out_rdy;
  logic [3:0][CH-1:0][PW-1:0] s_in_pld, s_out_pld;
  logic                       s_route_err;
  logic [15:0]                s_stall_cnt;

  logic [3:0][CH-1:0]         d_in_vld, d_in_rdy, d_out_vld, d_out_rdy;
  logic [3:0][CH-1:0][PW-1:0] d_in_pld, d_out_pld;
  logic                       d_route_err;
  logic [15:0]                d_stall_cnt;

  xy_router_node #(.CH_NUM(CH), .PLD_W(PW), .DIR_LSB(0), .FIFO_DEPTH(2), .DIAG(0)) u_straight (
    .clk(clk), .rst(rst),
    .in_vld(s_in_vld), .in_pld(s_in_pld), .in_rdy(s_in_rdy),
    .out_vld(s_out_vld), .out_pld(s_out_pld), .out_rdy(s_out_rdy),
    .route_err(s_route_err), .stall_cnt(s_stall_cnt)
  );

  xy_router_node #(.CH_NUM(CH), .PLD_W(PW), .DIR_LSB(0), .FIFO_DEPTH(2), .DIAG(1)) u_diag (
    .clk(clk), .rst(rst),
    .in_vld(d_in_vld), .in_pld(d_in_pld), .in_rdy(d_in_rdy),
    .out_vld(d_out_vld), .out_pld(d_out_pld), .out_rdy(d_out_rdy),
    .route_err(d_route_err), .stall_cnt(d_stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    s_in_vld = '0; s_in_pld = '0; s_out_rdy = '1;
    d_in_vld = '0; d_in_pld = '0; d_out_rdy = '1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    #12;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    #12;
    total_cnt++; if (s_out_vld !== '0) $display("FAIL rst_s_out_vld: got %h expected 0", s_out_vld); else pass_cnt++;
    total_cnt++; if (d_out_vld !== '0) $display("FAIL rst_d_out_vld: got %h expected 0", d_out_vld); else pass_cnt++;
    total_cnt++; if (s_out_pld !== '0) $display("FAIL rst_s_out_pld: got %h expected 0", s_out_pld); else pass_cnt++;
    total_cnt++; if (d_out_pld !== '0) $display("FAIL rst_d_out_pld: got %h expected 0", d_out_pld); else pass_cnt++;
    total_cnt++; if ({s_route_err, d_route_err} !== 2'b00) $display("FAIL rst_route_err: got %b%b expected 00", s_route_err, d_route_err); else pass_cnt++;
    total_cnt++; if (s_stall_cnt !== 16'h0 || d_stall_cnt !== 16'h0) $display("FAIL rst_stall_cnt: got %h/%h expected 0/0", s_stall_cnt, d_stall_cnt); else pass_cnt++;
    total_cnt++; if (s_in_rdy !== '1) $display("FAIL rst_s_in_rdy: got %h expected all ones", s_in_rdy); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_straight;
    logic [3:0][CH-1:0] exp_v;
    s_in_vld[0][3] = 1'b1; s_in_pld[0][3] = 16'h00A5;
    #1;
    total_cnt++; if (s_in_rdy[0][3] !== 1'b1) $display("FAIL st_w3_rdy: got %b expected 1", s_in_rdy[0][3]); else pass_cnt++;
    tick();
    s_in_vld[0][3] = 1'b0;
    exp_v = '0; exp_v[1][3] = 1'b1;
    total_cnt++; if (s_out_vld !== exp_v) $display("FAIL st_e3_vld: got %h expected %h", s_out_vld, exp_v); else pass_cnt++;
    total_cnt++; if (s_out_pld[1][3] !== 16'h00A5) $display("FAIL st_e3_pld: got %h expected 00a5", s_out_pld[1][3]); else pass_cnt++;
    tick();
    total_cnt++; if (s_out_vld !== '0) $display("FAIL st_drained: got %h expected 0", s_out_vld); else pass_cnt++;
    total_cnt++; if (s_out_pld[1][3] !== 16'h00A5) $display("FAIL st_idle_hold: got %h expected 00a5", s_out_pld[1][3]); else pass_cnt++;
    s_in_vld[2][6] = 1'b1; s_in_pld[2][6] = 16'hBEEF;
    tick();
    s_in_vld[2][6] = 1'b0;
    exp_v = '0; exp_v[3][6] = 1'b1;
    total_cnt++; if (s_out_vld !== exp_v) $display("FAIL st_n6_vld: got %h expected %h", s_out_vld, exp_v); else pass_cnt++;
    total_cnt++; if (s_out_pld[3][6] !== 16'hBEEF) $display("FAIL st_n6_pld: got %h expected beef", s_out_pld[3][6]); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure;
    s_out_rdy[1][0] = 1'b0;
    s_in_vld[0][0] = 1'b1; s_in_pld[0][0] = 16'h0011;
    #1;
    total_cnt++; if (s_in_rdy[0][0] !== 1'b1) $display("FAIL bp_rdy_b0: got %b expected 1", s_in_rdy[0][0]); else pass_cnt++;
    tick();
    s_in_pld[0][0] = 16'h0022;
    #1;
    total_cnt++; if (s_in_rdy[0][0] !== 1'b1) $display("FAIL bp_rdy_b1: got %b expected 1", s_in_rdy[0][0]); else pass_cnt++;
    tick();
    s_in_pld[0][0] = 16'h0033;
    #1;
    total_cnt++; if (s_in_rdy[0][0] !== 1'b0) $display("FAIL bp_rdy_full: got %b expected 0", s_in_rdy[0][0]); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (s_stall_cnt !== 16'd3) $display("FAIL bp_stall3: got %0d expected 3", s_stall_cnt); else pass_cnt++;
    total_cnt++; if (s_out_pld[1][0] !== 16'h0011) $display("FAIL bp_head0: got %h expected 0011", s_out_pld[1][0]); else pass_cnt++;
    s_out_rdy[1][0] = 1'b1;
    #1;
    total_cnt++; if (s_in_rdy[0][0] !== 1'b0) $display("FAIL bp_rdy_no_outrdy_path: got %b expected 0", s_in_rdy[0][0]); else pass_cnt++;
    tick();
    total_cnt++; if (s_stall_cnt !== 16'd4) $display("FAIL bp_stall4: got %0d expected 4", s_stall_cnt); else pass_cnt++;
    total_cnt++; if (s_out_pld[1][0] !== 16'h0022) $display("FAIL bp_head1: got %h expected 0022", s_out_pld[1][0]); else pass_cnt++;
    total_cnt++; if (s_in_rdy[0][0] !== 1'b1) $display("FAIL bp_rdy_after_pop: got %b expected 1", s_in_rdy[0][0]); else pass_cnt++;
    tick();
    total_cnt++; if (s_out_pld[1][0] !== 16'h0033) $display("FAIL bp_head2: got %h expected 0033", s_out_pld[1][0]); else pass_cnt++;
    s_in_pld[0][0] = 16'h0044;
    tick();
    s_in_vld[0][0] = 1'b0;
    total_cnt++; if (s_out_vld[1][0] !== 1'b1 || s_out_pld[1][0] !== 16'h0044) $display("FAIL bp_head3: got %b/%h expected 1/0044", s_out_vld[1][0], s_out_pld[1][0]); else pass_cnt++;
    tick();
    total_cnt++; if (s_out_vld !== '0) $display("FAIL bp_empty: got %h expected 0", s_out_vld); else pass_cnt++;
    total_cnt++; if (s_stall_cnt !== 16'd4) $display("FAIL bp_stall_final: got %0d expected 4", s_stall_cnt); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic [PW-1:0] src_pld [3];
    logic [2:0]    exp_g;
    logic [2:0]    got_g;
    src_pld[0] = 16'hA000; src_pld[1] = 16'hB000; src_pld[2] = 16'hC000;
    d_in_vld[0][5] = 1'b1; d_in_pld[0][5] = src_pld[0];
    d_in_vld[3][5] = 1'b1; d_in_pld[3][5] = src_pld[1];
    d_in_vld[2][5] = 1'b1; d_in_pld[2][5] = src_pld[2];
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_g = 3'b100 >> (i % 3);
      got_g = {d_in_rdy[0][5], d_in_rdy[3][5], d_in_rdy[2][5]};
      total_cnt++; if (got_g !== exp_g) $display("FAIL rr_grant%0d: got %b expected %b (W,N,S)", i, got_g, exp_g); else pass_cnt++;
      tick();
      total_cnt++; if (d_out_vld[1][5] !== 1'b1 || d_out_pld[1][5] !== src_pld[i % 3]) $display("FAIL rr_out%0d: got %b/%h expected 1/%h", i, d_out_vld[1][5], d_out_pld[1][5], src_pld[i % 3]); else pass_cnt++;
    end
    d_in_vld = '0;
    tick();
  endtask

  task automatic test_steer;
    logic [PW-1:0]      beat [3];
    int                 port [3];
    logic [3:0][CH-1:0] exp_v;
    beat[0] = 16'h1100; port[0] = 0;
    beat[1] = 16'h2202; port[1] = 2;
    beat[2] = 16'h3303; port[2] = 3;
    for (int i = 0; i < 3; i++) begin
      d_in_vld[1][1] = 1'b1; d_in_pld[1][1] = beat[i];
      #1;
      total_cnt++; if (d_in_rdy[1][1] !== 1'b1) $display("FAIL steer_rdy%0d: got %b expected 1", i, d_in_rdy[1][1]); else pass_cnt++;
      tick();
      exp_v = '0; exp_v[port[i]][1] = 1'b1;
      total_cnt++; if (d_out_vld !== exp_v) $display("FAIL steer_vld%0d: got %h expected %h", i, d_out_vld, exp_v); else pass_cnt++;
      total_cnt++; if (d_out_pld[port[i]][1] !== beat[i]) $display("FAIL steer_pld%0d: got %h expected %h", i, d_out_pld[port[i]][1], beat[i]); else pass_cnt++;
    end
    d_in_vld[1][1] = 1'b0;
    tick();
    d_out_rdy[0][1] = 1'b0;
    d_in_vld[1][1] = 1'b1; d_in_pld[1][1] = 16'h4400;
    tick();
    d_in_pld[1][1] = 16'h4500;
    tick();
    d_in_pld[1][1] = 16'h4600;
    #1;
    total_cnt++; if (d_in_rdy[1][1] !== 1'b0) $display("FAIL steer_w_full_rdy: got %b expected 0", d_in_rdy[1][1]); else pass_cnt++;
    d_in_pld[1][1] = 16'h4602;
    #1;
    total_cnt++; if (d_in_rdy[1][1] !== 1'b1) $display("FAIL steer_s_free_rdy: got %b expected 1", d_in_rdy[1][1]); else pass_cnt++;
    d_in_vld[1][1] = 1'b0;
    total_cnt++; if (d_out_pld[0][1] !== 16'h4400) $display("FAIL steer_w_head: got %h expected 4400", d_out_pld[0][1]); else pass_cnt++;
    total_cnt++; if (d_route_err !== 1'b0) $display("FAIL steer_no_err: got %b expected 0", d_route_err); else pass_cnt++;
    d_out_rdy[0][1] = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_route_err_and_reset;
    d_in_vld[1][0] = 1'b1; d_in_pld[1][0] = 16'h0001;
    #1;
    total_cnt++; if (d_in_rdy[1][0] !== 1'b1) $display("FAIL err_rdy: got %b expected 1", d_in_rdy[1][0]); else pass_cnt++;
    tick();
    d_in_vld[1][0] = 1'b0;
    total_cnt++; if (d_route_err !== 1'b1) $display("FAIL err_set: got %b expected 1", d_route_err); else pass_cnt++;
    total_cnt++; if (d_out_vld !== '0) $display("FAIL err_dropped: got %h expected 0", d_out_vld); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (d_route_err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", d_route_err); else pass_cnt++;
    d_out_rdy[1][5] = 1'b0;
    d_in_vld[0][5] = 1'b1; d_in_pld[0][5] = 16'h0A0A;
    tick(); tick();
    total_cnt++; if (d_out_vld[1][5] !== 1'b1) $display("FAIL rst_pre_vld: got %b expected 1", d_out_vld[1][5]); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (d_out_vld !== '0 || s_out_vld !== '0) $display("FAIL rst_async_vld: got %h/%h expected 0/0", d_out_vld, s_out_vld); else pass_cnt++;
    total_cnt++; if (d_route_err !== 1'b0) $display("FAIL rst_async_err: got %b expected 0", d_route_err); else pass_cnt++;
    total_cnt++; if (d_stall_cnt !== 16'h0 || s_stall_cnt !== 16'h0) $display("FAIL rst_async_stall: got %h/%h expected 0/0", d_stall_cnt, s_stall_cnt); else pass_cnt++;
    total_cnt++; if (d_out_pld !== '0) $display("FAIL rst_async_pld: got %h expected 0", d_out_pld); else pass_cnt++;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stall_saturate;
    s_out_rdy[1][0] = 1'b0;
    s_in_vld[0][0] = 1'b1; s_in_pld[0][0] = 16'h0077;
    repeat (65536) tick();
    total_cnt++; if (s_stall_cnt !== 16'hFFFE) $display("FAIL sat_pre: got %h expected fffe", s_stall_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (s_stall_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", s_stall_cnt); else pass_cnt++;
    repeat (4000) tick();
    total_cnt++; if (s_stall_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", s_stall_cnt); else pass_cnt++;
    total_cnt++; if (s_in_rdy[0][0] !== 1'b0) $display("FAIL sat_blocked: got %b expected 0", s_in_rdy[0][0]); else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_round_robin();
    test_steer();
    test_route_err_and_reset();
    do_reset();
    test_stall_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
